// File: rtl/fft_butterfly_core_if.sv
// Handshake and operand/result bundle for the radix-2 butterfly core.
// The controller side is master; the core is slave.
interface fft_butterfly_core_if #(
    parameter int WIDTH = 8
);
    logic                    start;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] b_re;
    logic signed [WIDTH-1:0] b_im;
    logic signed [WIDTH-1:0] w_re;
    logic signed [WIDTH-1:0] w_im;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] y_re;
    logic signed [WIDTH-1:0] y_im;
    logic signed [WIDTH-1:0] z_re;
    logic signed [WIDTH-1:0] z_im;
    logic                    ovf;

    modport master (
        output start, a_re, a_im, b_re, b_im, w_re, w_im,
        input  busy, done, y_re, y_im, z_re, z_im, ovf
    );

    modport slave (
        input  start, a_re, a_im, b_re, b_im, w_re, w_im,
        output busy, done, y_re, y_im, z_re, z_im, ovf
    );
endinterface

// File: rtl/fft_butterfly_core.sv
// Radix-2 DIT butterfly: Y = A + W*B, Z = A - W*B in signed Q1.(WIDTH-1).
// One shared multiplier is stepped over four cycles.
module fft_butterfly_core #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    fft_butterfly_core_if.slave  bus
);
    localparam int AW = 2 * WIDTH + 1;
    localparam int TW = WIDTH + 2;
    localparam int SW = WIDTH + 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MUL_RR = 3'd1;
    localparam logic [2:0] MUL_II = 3'd2;
    localparam logic [2:0] MUL_RI = 3'd3;
    localparam logic [2:0] MUL_IR = 3'd4;
    localparam logic [2:0] ADD    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = -SW'(2 ** (WIDTH - 1));

    logic [2:0] state;

    logic signed [WIDTH-1:0] ar, ai, br, bi, wr, wi;
    logic signed [AW-1:0]    acc;
    logic signed [TW-1:0]    t_re, t_im;

    logic signed [WIDTH-1:0]   m_a, m_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      prod_x;
    logic signed [AW-1:0]      acc_nx;
    logic signed [TW-1:0]      t_rnd;

    logic signed [SW-1:0] a_re_x, a_im_x, t_re_x, t_im_x;
    logic [WIDTH:0]       sy_re, sy_im, sz_re, sz_im;

    function automatic logic [WIDTH:0] sat(input logic signed [SW-1:0] s);
        if (s > SMAX)
            return {1'b1, SMAX[WIDTH-1:0]};
        else if (s < SMIN)
            return {1'b1, SMIN[WIDTH-1:0]};
        else
            return {1'b0, s[WIDTH-1:0]};
    endfunction

    always_comb begin
        m_a = br;
        m_b = wr;
        unique case (state)
            MUL_II: begin m_a = bi; m_b = wi; end
            MUL_RI: begin m_a = br; m_b = wi; end
            MUL_IR: begin m_a = bi; m_b = wr; end
            default: ;
        endcase
    end

    assign prod   = m_a * m_b;
    assign prod_x = {prod[2*WIDTH-1], prod};

    always_comb begin
        acc_nx = prod_x;
        unique case (state)
            MUL_II:  acc_nx = acc - prod_x;
            MUL_IR:  acc_nx = acc + prod_x;
            default: ;
        endcase
    end

    // Round half up, then keep enough headroom for +/-256 after scaling.
    assign t_rnd = TW'((acc_nx + HALF) >>> FRAC);

    assign a_re_x = {{3{ar[WIDTH-1]}}, ar};
    assign a_im_x = {{3{ai[WIDTH-1]}}, ai};
    assign t_re_x = {t_re[TW-1], t_re};
    assign t_im_x = {t_im[TW-1], t_im};

    assign sy_re = sat(a_re_x + t_re_x);
    assign sy_im = sat(a_im_x + t_im_x);
    assign sz_re = sat(a_re_x - t_re_x);
    assign sz_im = sat(a_im_x - t_im_x);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ar       <= '0;
            ai       <= '0;
            br       <= '0;
            bi       <= '0;
            wr       <= '0;
            wi       <= '0;
            acc      <= '0;
            t_re     <= '0;
            t_im     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.y_re <= '0;
            bus.y_im <= '0;
            bus.z_re <= '0;
            bus.z_im <= '0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ar       <= bus.a_re;
                        ai       <= bus.a_im;
                        br       <= bus.b_re;
                        bi       <= bus.b_im;
                        wr       <= bus.w_re;
                        wi       <= bus.w_im;
                        bus.busy <= 1'b1;
                        state    <= MUL_RR;
                    end
                end
                MUL_RR: begin
                    acc   <= acc_nx;
                    state <= MUL_II;
                end
                MUL_II: begin
                    acc   <= acc_nx;
                    t_re  <= t_rnd;
                    state <= MUL_RI;
                end
                MUL_RI: begin
                    acc   <= acc_nx;
                    state <= MUL_IR;
                end
                MUL_IR: begin
                    acc   <= acc_nx;
                    t_im  <= t_rnd;
                    state <= ADD;
                end
                ADD: begin
                    bus.y_re <= sy_re[WIDTH-1:0];
                    bus.y_im <= sy_im[WIDTH-1:0];
                    bus.z_re <= sz_re[WIDTH-1:0];
                    bus.z_im <= sz_im[WIDTH-1:0];
                    bus.ovf  <= sy_re[WIDTH] | sy_im[WIDTH] |
                                sz_re[WIDTH] | sz_im[WIDTH];
                    state    <= DONE;
                end
                DONE: begin
                    // Pulse lands as we re-enter IDLE, so a new start fits next edge.
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_butterfly_core.sv
// Scoreboard bench for fft_butterfly_core: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_fft_butterfly_core;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        int yr;
        int yi;
        int zr;
        int zi;
        int ov;
        int at;
    } exp_t;

    exp_t sb[$];

    fft_butterfly_core_if #(.WIDTH(8)) bus ();

    fft_butterfly_core #(.WIDTH(8), .FRAC(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.at);
                chk("y_re", int'(bus.y_re), e.yr);
                chk("y_im", int'(bus.y_im), e.yi);
                chk("z_re", int'(bus.z_re), e.zr);
                chk("z_im", int'(bus.z_im), e.zi);
                chk("ovf", int'(bus.ovf), e.ov);
                chk("busy_at_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic drive(input int ar, ai, br, bi, wr, wi);
        bus.a_re = 8'(ar);
        bus.a_im = 8'(ai);
        bus.b_re = 8'(br);
        bus.b_im = 8'(bi);
        bus.w_re = 8'(wr);
        bus.w_im = 8'(wi);
    endtask

    // Called just after a negedge; start is sampled at the next posedge.
    task automatic issue(input int ar, ai, br, bi, wr, wi,
                         input int yr, yi, zr, zi, ov, input bit push);
        exp_t e;
        drive(ar, ai, br, bi, wr, wi);
        bus.start = 1'b1;
        if (push) begin
            e = '{yr, yi, zr, zi, ov, cyc + 7};
            sb.push_back(e);
        end
        @(negedge clock);
        bus.start = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || bus.busy) begin
            tests++;
            fails++;
            $display("FAIL timeout: pending=%0d busy=%0d", sb.size(), bus.busy);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic chk_outs(input string tag, input int yr, yi, zr, zi);
        chk({tag, "_y_re"}, int'(bus.y_re), yr);
        chk({tag, "_y_im"}, int'(bus.y_im), yi);
        chk({tag, "_z_re"}, int'(bus.z_re), zr);
        chk({tag, "_z_im"}, int'(bus.z_im), zi);
    endtask

    initial begin
        bus.start = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk_outs("rst", 0, 0, 0, 0);

        issue(64, 0, 64, 0, 127, 0, 127, 0, 0, 0, 1, 1);
        wait_idle();
        issue(10, 20, 64, 0, 0, -128, 10, -44, 10, 84, 0, 1);
        wait_idle();
        issue(0, 0, 100, 0, 91, -91, 71, -71, -71, 71, 0, 1);
        wait_idle();
        issue(0, 0, -128, 0, -128, 0, 127, 0, -128, 0, 1, 1);
        wait_idle();
        issue(-128, 0, 127, 0, 127, 0, -2, 0, -128, 0, 1, 1);
        wait_idle();

        // Abort in MUL_RI: outputs clear, no done pulse follows.
        issue(10, 20, 64, 0, 0, -128, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_ovf", int'(bus.ovf), 0);
        chk_outs("abort", 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("abort_idle_busy", int'(bus.busy), 0);

        // Start during busy is ignored; start right after done is taken.
        issue(0, 0, 100, 0, 91, -91, 71, -71, -71, 71, 0, 1);
        drive(0, 0, -128, 0, -128, 0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.done && n < 20) begin
                @(negedge clock);
                n++;
            end
            chk("done_seen", int'(bus.done), 1);
        end
        issue(10, 20, 64, 0, 0, -128, 10, -44, 10, 84, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_busy", int'(bus.busy), 1);
            chk_outs("hold", 71, -71, -71, 71);
            @(negedge clock);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_butterfly_core.md
Name: fft_butterfly_core

Overview:
- Radix-2 decimation-in-time butterfly datapath. It consumes the operands and twiddle factor collected by the switch-driven FFT control FSM.
- Produces Y = A + W·B and Z = A − W·B in signed Q1.7, which the controller then shows on the LEDs one component at a time.
- Uses a single shared 8×8 signed multiplier, time-multiplexed over four cycles, with a start/busy/done handshake.

Parameters:
- WIDTH, 8: data width of every operand and result (signed, Q1.(WIDTH−1)).
- FRAC, 7: fractional bits. Products are rounded by shifting right FRAC.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request. Sampled only in IDLE.
- a_re, input, WIDTH: real part of operand A, signed.
- a_im, input, WIDTH: imaginary part of operand A, signed.
- b_re, input, WIDTH: real part of operand B, signed.
- b_im, input, WIDTH: imaginary part of operand B, signed.
- w_re, input, WIDTH: real part of the twiddle factor, signed Q1.7 (e.g. W^0 = 127, 0).
- w_im, input, WIDTH: imaginary part of the twiddle factor, signed Q1.7.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse. Results are valid from this cycle.
- y_re, output, WIDTH: real part of the sum output.
- y_im, output, WIDTH: imaginary part of the sum output.
- z_re, output, WIDTH: real part of the difference output.
- z_im, output, WIDTH: imaginary part of the difference output.
- ovf, output, 1: set if any of the four outputs saturated in the last operation.

Behaviour:
- Reset (asynchronous, any time): state = IDLE; busy = 0, done = 0, ovf = 0; all y/z outputs = 0; internal registers cleared.
  - Reset during an operation aborts it. No done pulse is produced.
- States: IDLE → MUL_RR → MUL_II → MUL_RI → MUL_IR → ADD → DONE → IDLE.
- IDLE:
  - start = 1 at a rising edge latches a, b and w into internal registers, sets busy and enters MUL_RR.
  - Inputs may change freely after that edge.
- MUL_RR: acc = b_re·w_re (full 2·WIDTH-bit product, sign-extended into a (2·WIDTH+1)-bit accumulator).
- MUL_II: acc = acc − b_im·w_im. Then t_re = (acc + 2^(FRAC−1)) >>> FRAC.
  - Rounding is round-half-up; the shift is arithmetic.
  - t_re is WIDTH+2 bits wide.
- MUL_RI: acc = b_re·w_im.
- MUL_IR: acc = acc + b_im·w_re. t_im is rounded the same way as t_re.
- ADD:
  - y = a + t and z = a − t, computed at WIDTH+3 bits.
  - Each component saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Results are registered into y_*/z_*. ovf = OR of the four saturation flags.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE.
- Latency: done is high in the cycle after the 6th rising edge following the edge that sampled start.
  - A new start is accepted in the cycle after done (IDLE), giving a throughput of 1 operation per 7 cycles.
- start while busy (MUL_RR..DONE) is ignored. It is not queued and has no effect on latched operands.
- Outputs y/z/ovf hold their values until the ADD state of the next operation. They do not change while a new operation is in its multiply states.
- A start held high continuously restarts an operation on every IDLE visit.
- −128 × −128 = +16384 must not wrap; the accumulator width guarantees this.

Test Plan:
- Reset, then idle → busy = 0, done = 0, ovf = 0 and all outputs 0. Assert reset mid-operation (in MUL_RI) → outputs return to 0 and no done pulse appears.
- a = (64, 0), b = (64, 0), w = (127, 0), start → exactly 6 edges later done = 1, y = (127, 0) saturated, z = (0, 0), ovf = 1.
- a = (10, 20), b = (64, 0), w = (0, −128) → t = (0, −64), y = (10, −44), z = (10, 84), ovf = 0.
- a = (0, 0), b = (100, 0), w = (91, −91) → y = (71, −71), z = (−71, 71). a = (0, 0), b = (−128, 0), w = (−128, 0) → y = (127, 0), z = (−128, 0), ovf = 1.
- a = (−128, 0), b = (127, 0), w = (127, 0) → t_re = 126, y_re = −2, z_re = −128, ovf = 1.
- Pulse start again on the 2nd cycle of busy with different operands → ignored; results match the first operands. A start in the cycle after done is accepted, and the previous outputs hold until the new ADD.
